// File: rtl/stall_data_mem.sv
// Multi-cycle data memory responder: accepts one word-aligned read or write,
// holds Stall while the access is in flight, then pulses Done with read data.
module stall_data_mem #(
    parameter int ADDR_W  = 13,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    state_t            r_state;
    logic [3:0]        r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [15:0]       r_wdata;
    logic              r_is_wr;
    logic [15:0]       r_mem [2**ADDR_W];

    logic w_can_accept;
    logic w_legal;
    logic w_accept;
    logic w_illegal;
    logic w_finish;
    logic w_mem_we;

    // Requests are only looked at outside BUSY; a request is legal when
    // exactly one of Rd/Wr is set and the address is word aligned.
    assign w_can_accept = (r_state != S_BUSY);
    assign w_legal      = (Rd ^ Wr) && !Addr[0];
    assign w_accept     = w_can_accept && w_legal;
    assign w_illegal    = w_can_accept && (Rd || Wr) && !w_legal;
    assign w_finish     = (r_state == S_BUSY) && (r_count == 4'd0);
    // Gated by rst so a reset on the completing edge drops the pending write.
    assign w_mem_we     = w_finish && r_is_wr && rst;

    // Address bits above the word index are deliberately ignored (wrap).
    if (ADDR_W < 15) begin : g_unused
        logic w_unused_addr;
        assign w_unused_addr = ^Addr[15:ADDR_W+1];
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the values from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 16'd0;
            r_is_wr <= 1'b0;
            DataOut <= 16'd0;
            Done    <= 1'b0;
            Stall   <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_idx   <= Addr[ADDR_W:1];
                        r_wdata <= DataIn;
                        r_is_wr <= Wr;
                        r_count <= CNT_LOAD;
                        r_state <= S_BUSY;
                        Stall   <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        Stall   <= 1'b0;
                    end
                    Done <= 1'b0;
                    if (w_illegal) begin
                        err <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_state <= S_RESP;
                        Stall   <= 1'b0;
                        Done    <= 1'b1;
                        if (!r_is_wr) begin
                            DataOut <= r_mem[r_idx];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    Stall   <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; contents survive reset and are
    // undefined at power-up, which also lets it map onto a block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_stall_data_mem.sv
// Randomised self-checking bench for stall_data_mem: directed scenarios plus
// random traffic against a cycle-timing and associative-array memory model.
module tb_stall_data_mem;

    localparam int L0  = 4;
    localparam int AW0 = 13;
    localparam int L1  = 2;
    localparam int AW1 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_addr, a_din, a_dout;
    logic        a_rd, a_wr, a_done, a_stall, a_err;
    logic [15:0] b_addr, b_din, b_dout;
    logic        b_rd, b_wr, b_done, b_stall, b_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word memory keyed by word index, plus expected
    // DataOut and sticky error state.
    logic [15:0] mdl_mem [int];
    logic [15:0] mdl_out;
    bit          mdl_out_known;
    bit          mdl_err;
    logic [12:0] pool [8];

    stall_data_mem #(.ADDR_W(AW0), .LATENCY(L0)) u_dut_a (
        .clk(clk), .rst(rst), .Addr(a_addr), .DataIn(a_din), .Rd(a_rd), .Wr(a_wr),
        .DataOut(a_dout), .Done(a_done), .Stall(a_stall), .err(a_err)
    );

    stall_data_mem #(.ADDR_W(AW1), .LATENCY(L1)) u_dut_b (
        .clk(clk), .rst(rst), .Addr(b_addr), .DataIn(b_din), .Rd(b_rd), .Wr(b_wr),
        .DataOut(b_dout), .Done(b_done), .Stall(b_stall), .err(b_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int key_of(input logic [15:0] addr, input int aw);
        return (int'(addr) / 2) % (1 << aw);
    endfunction

    // Issue one legal request to DUT A from a negedge; returns at the negedge
    // of its Done cycle, where the caller may present the next request.
    task automatic req_a(input bit is_wr, input logic [15:0] addr, input logic [15:0] data);
        int k;
        k = key_of(addr, AW0);
        a_addr = addr; a_din = data; a_rd = !is_wr; a_wr = is_wr;
        if (is_wr) begin
            mdl_mem[k] = data;
        end else if (mdl_mem.exists(k)) begin
            mdl_out = mdl_mem[k];
            mdl_out_known = 1'b1;
        end else begin
            mdl_out_known = 1'b0;
        end
        for (int c = 1; c <= L0; c++) begin
            @(negedge clk);
            if (c < L0) begin
                check("busy_stall", 32'(a_stall), 32'd1);
                check("busy_done", 32'(a_done), 32'd0);
                // Anything driven while busy must be ignored.
                a_addr = 16'($urandom); a_din = 16'($urandom);
                a_rd = 1'($urandom); a_wr = 1'($urandom);
            end else begin
                check("resp_done", 32'(a_done), 32'd1);
                check("resp_stall", 32'(a_stall), 32'd0);
                if (mdl_out_known) check("resp_data", 32'(a_dout), 32'(mdl_out));
                a_rd = 1'b0; a_wr = 1'b0;
            end
            check("err_state", 32'(a_err), 32'(mdl_err));
        end
    endtask

    task automatic bad_a(input bit both, input logic [15:0] addr);
        a_addr = addr; a_din = 16'($urandom);
        a_rd = 1'b1; a_wr = both;
        mdl_err = 1'b1;
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0;
        check("bad_stall", 32'(a_stall), 32'd0);
        check("bad_done", 32'(a_done), 32'd0);
        check("bad_err", 32'(a_err), 32'd1);
    endtask

    task automatic idle_a(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_stall", 32'(a_stall), 32'd0);
            check("idle_done", 32'(a_done), 32'd0);
            check("idle_err", 32'(a_err), 32'(mdl_err));
            if (mdl_out_known) check("idle_data", 32'(a_dout), 32'(mdl_out));
        end
    endtask

    task automatic reset_all();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mdl_err = 1'b0; mdl_out = 16'd0; mdl_out_known = 1'b1;
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_data", 32'(a_dout), 32'd0);
    endtask

    // Start a write on DUT A and reset it after 'cyc' busy cycles.
    task automatic write_then_reset(input int cyc, input logic [15:0] addr, input logic [15:0] data);
        a_addr = addr; a_din = data; a_wr = 1'b1; a_rd = 1'b0;
        @(negedge clk);
        a_wr = 1'b0;
        repeat (cyc - 1) @(negedge clk);
        reset_all();
    endtask

    task automatic req_b(input bit is_wr, input logic [15:0] addr, input logic [15:0] data,
                         input logic [15:0] exp_out);
        b_addr = addr; b_din = data; b_rd = !is_wr; b_wr = is_wr;
        @(negedge clk);
        b_rd = 1'b0; b_wr = 1'b0;
        check("b_busy_stall", 32'(b_stall), 32'd1);
        check("b_busy_done", 32'(b_done), 32'd0);
        @(negedge clk);
        check("b_resp_done", 32'(b_done), 32'd1);
        check("b_resp_stall", 32'(b_stall), 32'd0);
        check("b_resp_data", 32'(b_dout), 32'(exp_out));
        @(negedge clk);
        check("b_idle_stall", 32'(b_stall), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        a_addr = 16'd0; a_din = 16'd0; a_rd = 1'b0; a_wr = 1'b0;
        b_addr = 16'd0; b_din = 16'd0; b_rd = 1'b0; b_wr = 1'b0;
        mdl_err = 1'b0; mdl_out = 16'd0; mdl_out_known = 1'b1;
        repeat (2) @(negedge clk);
        reset_all();
        check("rst_b_stall", 32'(b_stall), 32'd0);
        check("rst_b_data", 32'(b_dout), 32'd0);

        // Basic write, read-back and hold.
        req_a(1'b1, 16'h0010, 16'hBEEF);
        idle_a(1);
        req_a(1'b0, 16'h0010, 16'h0000);
        check("readback", 32'(a_dout), 32'h0000BEEF);
        idle_a(10);
        check("hold_data", 32'(a_dout), 32'h0000BEEF);

        // Back-to-back: next request presented in the RESP cycle.
        req_a(1'b1, 16'h0020, 16'h1234);
        req_a(1'b0, 16'h0020, 16'h0000);
        check("b2b_data", 32'(a_dout), 32'h00001234);
        idle_a(1);

        // Illegal requests set the sticky error but leave traffic working.
        bad_a(1'b1, 16'h0004);
        idle_a(1);
        bad_a(1'b0, 16'h0005);
        idle_a(3);
        req_a(1'b0, 16'h0010, 16'h0000);
        check("post_err_data", 32'(a_dout), 32'h0000BEEF);
        idle_a(1);

        // Reset mid-write: mid-countdown, then on the completing edge.
        write_then_reset(2, 16'h0010, 16'h5555);
        idle_a(1);
        write_then_reset(L0 - 1, 16'h0010, 16'h6666);
        idle_a(1);
        req_a(1'b0, 16'h0010, 16'h0000);
        check("dropped_write", 32'(a_dout), 32'h0000BEEF);
        idle_a(1);

        // Random traffic over a small pool of word indices with random
        // ignored upper address bits.
        foreach (pool[i]) begin
            pool[i] = 13'($urandom);
            req_a(1'b1, {2'($urandom), pool[i], 1'b0}, 16'($urandom));
        end
        for (int n = 0; n < 80; n++) begin
            int sel;
            logic [15:0] addr;
            sel  = int'($urandom_range(0, 9));
            addr = {2'($urandom), pool[$urandom_range(0, 7)], 1'b0};
            if (sel == 0) bad_a(1'b1, addr);
            else if (sel == 1) bad_a(1'b0, addr | 16'd1);
            else req_a(sel < 5, addr, 16'($urandom));
            if ($urandom_range(0, 2) != 0) idle_a(int'($urandom_range(1, 2)));
        end
        idle_a(2);

        // Short-latency, narrow-address instance: 0x0022 aliases 0x0002.
        req_b(1'b1, 16'h0002, 16'hA5A5, 16'h0000);
        req_b(1'b0, 16'h0022, 16'h0000, 16'hA5A5);
        check("b_err", 32'(b_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
